// File: rtl/alu_op_sequencer.sv
// Purpose: steps one three-operand ALU instruction through T3..T6/DONE, driving datapath bus and load strobes.
// Latency: done pulses 4 cycles after an accepted start (5 for MUL/DIV); all outputs are registered.
// Backpressure: start is taken only in IDLE; requests while busy (DONE included) are dropped, not queued.
module alu_op_sequencer #(
    parameter logic [3:0] OP_MUL = 4'b1010,
    parameter logic [3:0] OP_DIV = 4'b1011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    output logic        busy,
    output logic        done,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [3:0]  alu_op,
    output logic [2:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  rc_q, rc_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] rout_q, rout_d;
    logic [15:0] rin_q, rin_d;
    logic        yin_q, yin_d;
    logic        zin_q, zin_d;
    logic        zlo_q, zlo_d;
    logic        zhi_q, zhi_d;
    logic        loin_q, loin_d;
    logic        hiin_q, hiin_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        long_op;

    assign long_op = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_comb begin
        state_d = S_IDLE;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T3;
                    op_d    = opcode;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                end
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = long_op ? S_T6 : S_DONE;
            S_T6:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and next latched fields so they appear
    // registered in the same cycle the state register enters that step.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rout_d   = '0;
        rin_d    = '0;
        yin_d    = 1'b0;
        zin_d    = 1'b0;
        zlo_d    = 1'b0;
        zhi_d    = 1'b0;
        loin_d   = 1'b0;
        hiin_d   = 1'b0;
        alu_op_d = (state_d != S_IDLE) ? op_d : 4'd0;
        case (state_d)
            S_T3: begin
                rout_d = 16'h0001 << rb_d;
                yin_d  = 1'b1;
            end
            S_T4: begin
                rout_d = 16'h0001 << rc_d;
                zin_d  = 1'b1;
            end
            S_T5: begin
                zlo_d = 1'b1;
                if ((op_d == OP_MUL) || (op_d == OP_DIV)) begin
                    loin_d = 1'b1;
                end else begin
                    rin_d = 16'h0001 << ra_d;
                end
            end
            S_T6: begin
                zhi_d  = 1'b1;
                hiin_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rout_q   <= '0;
            rin_q    <= '0;
            yin_q    <= 1'b0;
            zin_q    <= 1'b0;
            zlo_q    <= 1'b0;
            zhi_q    <= 1'b0;
            loin_q   <= 1'b0;
            hiin_q   <= 1'b0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rout_q   <= rout_d;
            rin_q    <= rin_d;
            yin_q    <= yin_d;
            zin_q    <= zin_d;
            zlo_q    <= zlo_d;
            zhi_q    <= zhi_d;
            loin_q   <= loin_d;
            hiin_q   <= hiin_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Rout     = rout_q;
    assign Rin      = rin_q;
    assign Yin      = yin_q;
    assign Zin      = zin_q;
    assign Zlowout  = zlo_q;
    assign Zhighout = zhi_q;
    assign LOin     = loin_q;
    assign HIin     = hiin_q;
    assign alu_op   = alu_op_q;
    assign step     = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle expected output vectors are queued
// when an instruction is issued and compared one per clock; an empty queue means IDLE.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        yin;
        logic        zin;
        logic        zlo;
        logic        zhi;
        logic        loin;
        logic        hiin;
        logic [3:0]  alu_op;
        logic [2:0]  step;
    } obs_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [3:0]  opcode, ra, rb, rc;
    logic        busy, done, Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rout, Rin;
    logic [3:0]  alu_op;
    logic [2:0]  step;

    obs_t obs;
    obs_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   done_before;

    alu_op_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .opcode   (opcode),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .busy     (busy),
        .done     (done),
        .Rout     (Rout),
        .Rin      (Rin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .LOin     (LOin),
        .HIin     (HIin),
        .alu_op   (alu_op),
        .step     (step)
    );

    always #5 clock = ~clock;

    assign obs = {busy, done, Rout, Rin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, alu_op, step};

    task automatic compare(input string tag, input obs_t got, input obs_t want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Expected per-cycle outputs of one instruction, starting with the cycle after acceptance.
    task automatic push_seq(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c);
        obs_t e;
        logic is_long;
        is_long = (op == 4'b1010) || (op == 4'b1011);
        e = '0; e.busy = 1'b1; e.alu_op = op; e.step = 3'd1;
        e.rout = 16'h0001 << b; e.yin = 1'b1;
        exp_q.push_back(e);
        e = '0; e.busy = 1'b1; e.alu_op = op; e.step = 3'd2;
        e.rout = 16'h0001 << c; e.zin = 1'b1;
        exp_q.push_back(e);
        e = '0; e.busy = 1'b1; e.alu_op = op; e.step = 3'd3; e.zlo = 1'b1;
        if (is_long) e.loin = 1'b1;
        else         e.rin  = 16'h0001 << a;
        exp_q.push_back(e);
        if (is_long) begin
            e = '0; e.busy = 1'b1; e.alu_op = op; e.step = 3'd4;
            e.zhi = 1'b1; e.hiin = 1'b1;
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.alu_op = op; e.step = 3'd5;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string tag);
        obs_t want;
        @(posedge clock);
        #1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
        if (obs.done) n_done++;
        compare(tag, obs, want);
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c);
        start = s; opcode = op; ra = a; rb = b; rc = c;
    endtask

    initial begin
        clear = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        compare("reset_state", obs, obs_t'('0));

        // Reset held: start and inputs toggling must not move the sequencer.
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 4'(i + 2), 4'(i), 4'(i + 1), 4'(i + 3));
            cyc("reset_held");
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        clear = 1'b1;
        cyc("post_release_idle");
        cyc("post_release_idle");

        // AND r2, r5, r6
        drive(1'b1, 4'b0010, 4'd2, 4'd5, 4'd6);
        push_seq(4'b0010, 4'd2, 4'd5, 4'd6);
        cyc("and_t3");
        start = 1'b0;
        cyc("and_t4");
        cyc("and_t5");
        cyc("and_done");
        cyc("and_idle");

        // MUL and DIV take the HI/LO write-back path.
        drive(1'b1, 4'b1010, 4'd1, 4'd3, 4'd4);
        push_seq(4'b1010, 4'd1, 4'd3, 4'd4);
        cyc("mul_t3");
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc("mul_seq");
        drive(1'b1, 4'b1011, 4'd9, 4'd14, 4'd0);
        push_seq(4'b1011, 4'd9, 4'd14, 4'd0);
        cyc("div_t3");
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc("div_seq");

        // start and field changes while busy are ignored; exactly one done.
        done_before = n_done;
        drive(1'b1, 4'b0010, 4'd2, 4'd5, 4'd6);
        push_seq(4'b0010, 4'd2, 4'd5, 4'd6);
        cyc("ign_t3");
        drive(1'b0, 4'b1010, 4'd11, 4'd12, 4'd13);
        cyc("ign_t4");
        drive(1'b1, 4'b1011, 4'd8, 4'd9, 4'd10);
        cyc("ign_t5");
        drive(1'b0, 4'b0111, 4'd1, 4'd1, 4'd1);
        cyc("ign_done");
        drive(1'b1, 4'b1010, 4'd3, 4'd3, 4'd3);
        cyc("ign_idle");
        start = 1'b0;
        cyc("ign_idle2");
        n_cmp++;
        assert (n_done - done_before == 1) else begin
            n_err++;
            $error("FAIL ign_done_count: observed %0d expected 1", n_done - done_before);
        end

        // Reset during T4 aborts immediately with no done pulse.
        done_before = n_done;
        drive(1'b1, 4'b0010, 4'd3, 4'd4, 4'd5);
        push_seq(4'b0010, 4'd3, 4'd4, 4'd5);
        cyc("abort_t3");
        start = 1'b0;
        cyc("abort_t4");
        clear = 1'b0;
        #1;
        compare("abort_immediate", obs, obs_t'('0));
        exp_q.delete();
        start = 1'b1;
        cyc("abort_held");
        cyc("abort_held");
        start = 1'b0;
        clear = 1'b1;
        cyc("abort_released");
        n_cmp++;
        assert (n_done == done_before) else begin
            n_err++;
            $error("FAIL abort_no_done: observed %0d expected %0d", n_done, done_before);
        end

        // All three register fields equal.
        drive(1'b1, 4'b0010, 4'd7, 4'd7, 4'd7);
        push_seq(4'b0010, 4'd7, 4'd7, 4'd7);
        cyc("same_t3");
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc("same_seq");

        // start held high: accepted every fifth edge.
        drive(1'b1, 4'b0010, 4'd1, 4'd2, 4'd3);
        for (int k = 0; k < 3; k++) begin
            push_seq(4'b0010, 4'd1, 4'd2, 4'd3);
            for (int i = 0; i < 5; i++) cyc("b2b");
        end
        start = 1'b0;
        cyc("b2b_tail");
        cyc("b2b_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control-step sequencer that drives the datapath's bus-enable and register-load strobes for one three-operand ALU instruction (e.g. `and Ra, Rb, Rc`). It is the initiator for the datapath/ALU interface: it issues the Rout/Yin/Zin/Zlowout/Rin steps that a testbench previously forced by hand. It sits between the instruction-control logic (which supplies opcode and register fields) and the datapath.

## Interface
- `OP_MUL`, default 4'b1010: opcode that needs the two-step HI/LO write-back.
- `OP_DIV`, default 4'b1011: opcode that needs the two-step HI/LO write-back.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset; **asynchronous, active-low**.
- `start`  in  1  request to execute one instruction; sampled only in IDLE.
- `opcode`  in  4  ALU opcode; 4'b0010 = AND.
- `ra`  in  4  destination register index.
- `rb`  in  4  source-1 register index.
- `rc`  in  4  source-2 register index.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `Rout`  out  16  one-hot register-to-bus enable.
- `Rin`  out  16  one-hot register load.
- `Yin`  out  1  Y-register load.
- `Zin`  out  1  Z-register load.
- `Zlowout`  out  1  Z[31:0] to bus.
- `Zhighout`  out  1  Z[63:32] to bus.
- `LOin`  out  1  LO load.
- `HIin`  out  1  HI load.
- `alu_op`  out  4  latched opcode to the ALU; held for the whole sequence.
- `step`  out  3  state encoding, for debug.

## Operation
- States: IDLE=0, T3=1, T4=2, T5=3, T6=4, DONE=5. Values 6 and 7 are illegal and return to IDLE on the next edge.
- In IDLE, when `start`=1 at a rising edge:
  - latch `opcode`, `ra`, `rb` and `rc`;
  - go to T3.
- T3: `Rout[rb]`=1, `Yin`=1.
- T4: `Rout[rc]`=1, `Zin`=1, `alu_op`=latched opcode.
- T5, ordinary op: `Zlowout`=1, `Rin[ra]`=1; next state DONE.
- T5, latched opcode equal to `OP_MUL` or `OP_DIV`: `Zlowout`=1, `LOin`=1, no `Rin`; next state T6.
- T6: `Zhighout`=1, `HIin`=1; next state DONE.
- DONE: `done`=1; next state IDLE.
- Strobes not listed for a state are 0. `Rout` and `Rin` are always one-hot or all-zero, never multi-hot.
- All strobes are decoded only from the state register and latched fields, never from live inputs. Input changes mid-sequence have no effect.
- `start` is ignored while `busy`=1, including the DONE cycle. It is not queued.
- `ra`, `rb` and `rc` may be equal to each other. Each strobe still asserts in its own state, e.g. rb==rc gives `Rout[rb]` in both T3 and T4.
- `alu_op` is 0 in IDLE and holds the latched opcode from T3 through DONE.

## Timing
- Reset (`clear`=0), asynchronous and immediate:
  - state=IDLE;
  - all outputs 0 (`busy`, `done`, `Rout`, `Rin`, every strobe, `alu_op`=0, `step`=0);
  - latched fields cleared.
- Reset asserted mid-sequence aborts without a `done` pulse. The first legal start is at the first rising edge after `clear` rises.
- Cycle numbering: `start` sampled high at edge 0.
  - Ordinary op: T3 in cycle 1, T4 in cycle 2, T5 in cycle 3, DONE in cycle 4, IDLE from cycle 5.
  - MUL/DIV: T3 in cycle 1, T4 in cycle 2, T5 in cycle 3, T6 in cycle 4, DONE in cycle 5, IDLE from cycle 6.
- Latency from start to `done`: 4 cycles for an ordinary op, 5 for MUL/DIV.
- Back-to-back: the next `start` can be accepted at edge 5 (edge 6 for MUL/DIV). Peak rate is one ordinary op per 5 cycles.
- Outputs are stable for the full cycle, so downstream registers load on the edge that ends the strobe cycle.

## Test plan
- Reset: hold `clear`=0, then toggle `start` and inputs -> all outputs stay 0 and `step`=0. Release `clear` -> still IDLE until `start`.
- AND: `start` with opcode=4'b0010, ra=2, rb=5, rc=6 ->
  - cycle 1: `Rout`=16'h0020, `Yin`=1;
  - cycle 2: `Rout`=16'h0040, `Zin`=1, `alu_op`=4'b0010;
  - cycle 3: `Zlowout`=1, `Rin`=16'h0004;
  - cycle 4: `done`=1;
  - cycle 5: `busy`=0.
- MUL: `start` with opcode=4'b1010, rb=3, rc=4 ->
  - cycle 3: `Zlowout`=1, `LOin`=1, `Rin`=0;
  - cycle 4: `Zhighout`=1, `HIin`=1;
  - cycle 5: `done`=1.
- Ignored start and input changes: pulse `start` again in cycles 2 and 4 with different ra/rb/rc/opcode -> original sequence is unchanged, and exactly one `done` pulse occurs.
- Reset mid-operation: drop `clear` during T4 -> all outputs 0 immediately, no `done` pulse. After release, a new AND with ra=rb=rc=7 -> `Rout`=16'h0080 in cycles 1 and 2, `Rin`=16'h0080 in cycle 3.
- Back-to-back: hold `start`=1 continuously with ra=1, rb=2, rc=3 -> T3 starts at cycles 1, 6, 11…, with `done` at cycles 4, 9, 14.
